// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each requester owns a single response slot; a full, undrained slot stalls only its owner.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_control,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_control,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_branch,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_y,
  output logic             rsp0_branch,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_y,
  output logic             rsp1_branch
);

  // Opcodes 1101..1111 are accepted but never use the ALU result.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= 4'd13);
  endfunction

  logic             last_q, last_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic [WIDTH-1:0] rsp0_y_q, rsp0_y_d;
  logic             rsp0_br_q, rsp0_br_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp1_y_q, rsp1_y_d;
  logic             rsp1_br_q, rsp1_br_d;

  logic             elig0, elig1, grant0, grant1;
  logic [WIDTH-1:0] cap_y;
  logic             cap_br;

  // A slot can accept new data when empty or being drained this cycle.
  always_comb begin
    elig0  = req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1  = req1_valid && (!rsp1_valid_q || rsp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (elig0 && (!elig1 || last_q)) grant0 = 1'b1;
      else if (elig1)                  grant1 = 1'b1;
    end
    last_d = last_q;
    if (grant0)      last_d = 1'b0;
    else if (grant1) last_d = 1'b1;
  end

  always_comb begin
    alu_control = 4'b0000;
    alu_a       = '0;
    alu_b       = '0;
    if (grant0) begin
      alu_control = req0_control;
      alu_a       = req0_a;
      alu_b       = req0_b;
    end else if (grant1) begin
      alu_control = req1_control;
      alu_a       = req1_a;
      alu_b       = req1_b;
    end
    cap_y  = is_illegal_op(alu_control) ? '0 : alu_y;
    cap_br = is_illegal_op(alu_control) ? 1'b0 : alu_branch;
  end

  // A grant on a draining slot reloads it, so valid stays high with no bubble.
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_y_d     = rsp0_y_q;
    rsp0_br_d    = rsp0_br_q;
    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_y_d     = cap_y;
      rsp0_br_d    = cap_br;
    end else if (rsp0_valid_q && rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    rsp1_valid_d = rsp1_valid_q;
    rsp1_y_d     = rsp1_y_q;
    rsp1_br_d    = rsp1_br_q;
    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_y_d     = cap_y;
      rsp1_br_d    = cap_br;
    end else if (rsp1_valid_q && rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp0_y_q     <= '0;
      rsp0_br_q    <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_y_q     <= '0;
      rsp1_br_q    <= 1'b0;
    end else begin
      last_q       <= last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_y_q     <= rsp0_y_d;
      rsp0_br_q    <= rsp0_br_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_y_q     <= rsp1_y_d;
      rsp1_br_q    <= rsp1_br_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_y      = rsp0_y_q;
  assign rsp0_branch = rsp0_br_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_y      = rsp1_y_q;
  assign rsp1_branch = rsp1_br_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the two response slots.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         rv[2];
  logic [3:0]   rc[2];
  logic [W-1:0] ra[2];
  logic [W-1:0] rb[2];
  logic         rr[2];

  logic         req0_ready, req1_ready;
  logic [3:0]   alu_control;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         alu_branch;
  logic         rsp0_valid, rsp1_valid, rsp0_branch, rsp1_branch;
  logic [W-1:0] rsp0_y, rsp1_y;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_control(rc[0]),
    .req0_a(ra[0]), .req0_b(rb[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_control(rc[1]),
    .req1_a(ra[1]), .req1_b(rb[1]),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_branch(alu_branch),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_y(rsp0_y), .rsp0_branch(rsp0_branch),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_y(rsp1_y), .rsp1_branch(rsp1_branch)
  );

  // Stand-in for the shared ALU; deliberately non-zero for the reserved opcodes.
  function automatic logic [W:0] ext_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] y;
    logic br;
    br = 1'b0;
    case (op)
      4'd0:  y = a + b;
      4'd1:  begin y = a - b; br = (a == b); end
      4'd2:  y = a & b;
      4'd3:  y = a | b;
      4'd4:  y = a ^ b;
      4'd12: begin y = a ^ b; br = ($signed(a) < $signed(b)); end
      default: begin y = a ^ ~b; br = 1'b1; end
    endcase
    return {br, y};
  endfunction

  assign {alu_branch, alu_y} = ext_alu(alu_control, alu_a, alu_b);

  function automatic logic [W:0] expected_result(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op >= 4'd13) return '0;
    return ext_alu(op, a, b);
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: one slot per requester, plus the index of the most recent grant.
  logic         m_vld[2];
  logic [W-1:0] m_y[2];
  logic         m_br[2];
  int           m_last;

  task automatic model_reset();
    m_vld[0] = 1'b0; m_vld[1] = 1'b0;
    m_last = 1;
  endtask

  function automatic int pick_winner();
    logic el[2];
    for (int i = 0; i < 2; i++) el[i] = rv[i] && (!m_vld[i] || rr[i]);
    if (el[0] && el[1]) return (m_last == 0) ? 1 : 0;
    if (el[0]) return 0;
    if (el[1]) return 1;
    return -1;
  endfunction

  // Called just after a rising edge with inputs set; returns the granted index (-1 none).
  task automatic do_cycle(output int g);
    logic [W:0] res;
    g = pick_winner();
    #1;
    check_val("req0_ready", req0_ready, g == 0);
    check_val("req1_ready", req1_ready, g == 1);
    check_val("alu_control", alu_control, (g >= 0) ? rc[g] : 4'd0);
    check_val("alu_a", alu_a, (g >= 0) ? ra[g] : '0);
    check_val("alu_b", alu_b, (g >= 0) ? rb[g] : '0);
    res = (g >= 0) ? expected_result(rc[g], ra[g], rb[g]) : '0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (g == i) begin
        m_vld[i] = 1'b1; m_y[i] = res[W-1:0]; m_br[i] = res[W];
      end else if (m_vld[i] && rr[i]) begin
        m_vld[i] = 1'b0;
      end
    end
    if (g >= 0) m_last = g;
    #1;
    check_val("rsp0_valid", rsp0_valid, m_vld[0]);
    check_val("rsp1_valid", rsp1_valid, m_vld[1]);
    if (m_vld[0]) begin
      check_val("rsp0_y", rsp0_y, m_y[0]);
      check_val("rsp0_branch", rsp0_branch, m_br[0]);
    end
    if (m_vld[1]) begin
      check_val("rsp1_y", rsp1_y, m_y[1]);
      check_val("rsp1_branch", rsp1_branch, m_br[1]);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    rv[i] = v; rc[i] = c; ra[i] = a; rb[i] = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 2'b00);
    check_val({tag, "_rsp_y"}, {rsp0_y, rsp1_y}, '0);
    check_val({tag, "_rsp_br"}, {rsp0_branch, rsp1_branch}, 2'b00);
    check_val({tag, "_req_ready"}, {req0_ready, req1_ready}, 2'b00);
    check_val({tag, "_alu"}, {alu_control, alu_a, alu_b}, '0);
  endtask

  initial begin
    int g;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b1, 4'd0, 32'd1, 32'd2);
      rr[i] = 1'b1;
    end
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    set_req(0, 1'b0, 4'd0, '0, '0);
    set_req(1, 1'b0, 4'd0, '0, '0);

    // Single add operation.
    set_req(0, 1'b1, 4'b0000, 32'd5, 32'd7);
    do_cycle(g);
    check_val("single_g", g, 0);
    check_val("single_y", rsp0_y, 32'd12);
    check_val("single_br", rsp0_branch, 1'b0);
    rv[0] = 1'b0;
    do_cycle(g);

    // Tie after a fresh reset alternates 0,1,0,1.
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, 4'b0000, 32'd10, 32'd20);
    set_req(1, 1'b1, 4'b0010, 32'hF0F0, 32'h0FF0);
    for (int k = 0; k < 4; k++) begin
      do_cycle(g);
      check_val("tie_g", g, k % 2);
    end
    rv[0] = 1'b0; rv[1] = 1'b0;
    do_cycle(g);

    // Backpressure on slot 0, then a no-bubble reload.
    rr[0] = 1'b0;
    set_req(0, 1'b1, 4'b0001, 32'd3, 32'd3);
    do_cycle(g);
    check_val("bp_first_g", g, 0);
    set_req(0, 1'b1, 4'b0001, 32'd4, 32'd3);
    for (int k = 0; k < 2; k++) begin
      do_cycle(g);
      check_val("bp_stall_g", g, -1);
      check_val("bp_hold_y", rsp0_y, 32'd0);
      check_val("bp_hold_br", rsp0_branch, 1'b1);
    end
    rr[0] = 1'b1;
    do_cycle(g);
    check_val("bp_reload_g", g, 0);
    check_val("bp_reload_vld", rsp0_valid, 1'b1);
    check_val("bp_reload_y", rsp0_y, 32'd1);
    check_val("bp_reload_br", rsp0_branch, 1'b0);

    // Slot 0 full and stalled must not block requester 1.
    rr[0] = 1'b0;
    set_req(0, 1'b1, 4'b0000, 32'd8, 32'd8);
    set_req(1, 1'b1, 4'b1100, 32'd9, 32'd9);
    rr[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_cycle(g);
      check_val("iso_g", g, 1);
      check_val("iso_y", rsp1_y, 32'd0);
      check_val("iso_br", rsp1_branch, 1'b0);
    end

    // Reserved opcode captured as zero.
    rv[0] = 1'b0;
    set_req(1, 1'b1, 4'b1111, '1, '1);
    do_cycle(g);
    check_val("illegal_g", g, 1);
    check_val("illegal_y", rsp1_y, 32'd0);
    check_val("illegal_br", rsp1_branch, 1'b0);
    rv[1] = 1'b0;

    // Reset between edges with a pending response.
    check_val("mid_pre_vld", rsp0_valid, 1'b1);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("mid");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_val("mid_after_vld", {rsp0_valid, rsp1_valid}, 2'b00);
    @(posedge clk); #1;
    check_val("mid_no_ghost", {rsp0_valid, rsp1_valid}, 2'b00);
    rr[0] = 1'b1; rr[1] = 1'b1;
    set_req(0, 1'b1, 4'b0011, 32'h12, 32'h30);
    set_req(1, 1'b1, 4'b0100, 32'h55, 32'hAA);
    do_cycle(g);
    check_val("mid_first_tie", g, 0);
    rv[0] = 1'b0; rv[1] = 1'b0;

    // Randomized traffic; requesters hold payload until accepted.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && ($urandom_range(0, 2) != 0)) begin
          rc[i] = 4'($urandom_range(0, 15));
          ra[i] = $urandom;
          rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
          rv[i] = 1'b1;
        end
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      do_cycle(g);
      if (g >= 0) rv[g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
